bus_timer: RTL and testbench

- 8-bit timer peripheral that acts as a responder on the CPU peripheral bus; the CPU is the initiator.
- Four memory-mapped registers at BASE..BASE+3: control, status, count, reload.
- Counts prescaled clock ticks and latches an overflow flag. The flag drives the CPU's level-sensitive irq input.
- Sits beside the CPU core and is the first irq source in the system.

---
 rtl/bus_timer_pkg.sv | 18 +
 rtl/timer_prescaler.sv | 31 +++
 rtl/bus_timer.sv | 126 ++++++++++++
 tb/tb_bus_timer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_timer_pkg.sv
// Shared register map and bit-field positions for the bus_timer peripheral.
package bus_timer_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STAT   = 2'd1;
    localparam logic [1:0] REG_CNT    = 2'd2;
    localparam logic [1:0] REG_RELOAD = 2'd3;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_ONESHOT  = 1;
    localparam int CTRL_IE       = 2;
    localparam int CTRL_PSEL_LSB = 3;
    localparam int CTRL_PSEL_MSB = 5;

    localparam int STAT_OVF = 0;
    localparam int STAT_RUN = 1;

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: emits a one-cycle tick every 2^psel enabled cycles.
module timer_prescaler #(
    parameter int PRESC_W = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       restart,
    input  logic [2:0] psel,
    output logic       tick
);

    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] terminal;

    always_comb begin
        terminal = PRESC_W'((32'd1 << psel) - 32'd1);
        tick     = en && (presc == terminal);
    end

    always_ff @(posedge clk) begin
        if (reset || !en || restart) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

endmodule

// File: rtl/bus_timer.sv
// 8-bit bus-mapped timer: CTRL/STAT/CNT/RELOAD registers, prescaled counting,
// sticky overflow flag and level interrupt.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [7:0] BASE    = 8'hF0,
    parameter int          PRESC_W = 7
) (
    input  logic       clk_ip,
    input  logic       reset,
    input  logic [7:0] bus_addr_ip,
    input  logic [7:0] bus_wdata_ip,
    input  logic       bus_we_ip,
    output logic [7:0] bus_rdata_op,
    output logic       bus_sel_op,
    output logic       irq_op
);

    logic       en, oneshot, ie, ovf;
    logic [2:0] psel;
    logic [7:0] cnt, reload;

    logic       en_n, oneshot_n, ie_n, ovf_n;
    logic [2:0] psel_n;
    logic [7:0] cnt_n, reload_n;

    logic       tick, tick_eff, ovf_set;
    logic       wr_ctrl, wr_stat, wr_cnt, wr_reload;
    logic [1:0] off;
    logic [7:0] ctrl_rd, stat_rd;

    assign bus_sel_op = (bus_addr_ip[7:2] == BASE[7:2]);
    assign off        = bus_addr_ip[1:0];
    assign wr_ctrl    = bus_we_ip && bus_sel_op && (off == REG_CTRL);
    assign wr_stat    = bus_we_ip && bus_sel_op && (off == REG_STAT);
    assign wr_cnt     = bus_we_ip && bus_sel_op && (off == REG_CNT);
    assign wr_reload  = bus_we_ip && bus_sel_op && (off == REG_RELOAD);

    timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk     (clk_ip),
        .reset   (reset),
        .en      (en),
        .restart (wr_ctrl),
        .psel    (psel),
        .tick    (tick)
    );

    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[CTRL_EN]      = en;
        ctrl_rd[CTRL_ONESHOT] = oneshot;
        ctrl_rd[CTRL_IE]      = ie;
        ctrl_rd[CTRL_PSEL_MSB:CTRL_PSEL_LSB] = psel;
        stat_rd = '0;
        stat_rd[STAT_OVF] = ovf;
        stat_rd[STAT_RUN] = en;

        bus_rdata_op = '0;
        if (bus_sel_op) begin
            case (off)
                REG_CTRL: bus_rdata_op = ctrl_rd;
                REG_STAT: bus_rdata_op = stat_rd;
                REG_CNT:  bus_rdata_op = cnt;
                default:  bus_rdata_op = reload;
            endcase
        end
    end

    // A CNT write swallows a coincident tick entirely, including its overflow.
    always_comb begin
        en_n      = en;
        oneshot_n = oneshot;
        ie_n      = ie;
        psel_n    = psel;
        cnt_n     = cnt;
        reload_n  = reload;
        ovf_set   = 1'b0;
        tick_eff  = tick && !wr_cnt;

        if (tick_eff) begin
            if (cnt == reload) begin
                cnt_n   = '0;
                ovf_set = 1'b1;
                if (oneshot) en_n = 1'b0;
            end else begin
                cnt_n = cnt + 8'd1;
            end
        end
        if (wr_cnt)    cnt_n    = bus_wdata_ip;
        if (wr_reload) reload_n = bus_wdata_ip;
        if (wr_ctrl) begin
            en_n      = bus_wdata_ip[CTRL_EN];
            oneshot_n = bus_wdata_ip[CTRL_ONESHOT];
            ie_n      = bus_wdata_ip[CTRL_IE];
            psel_n    = bus_wdata_ip[CTRL_PSEL_MSB:CTRL_PSEL_LSB];
        end

        // Set beats clear so an overflow landing on the clear cycle survives.
        ovf_n = ovf;
        if (wr_stat && bus_wdata_ip[STAT_OVF]) ovf_n = 1'b0;
        if (ovf_set) ovf_n = 1'b1;
    end

    always_ff @(posedge clk_ip) begin
        if (reset) begin
            en      <= 1'b0;
            oneshot <= 1'b0;
            ie      <= 1'b0;
            psel    <= '0;
            ovf     <= 1'b0;
            cnt     <= '0;
            reload  <= 8'hFF;
            irq_op  <= 1'b0;
        end else begin
            en      <= en_n;
            oneshot <= oneshot_n;
            ie      <= ie_n;
            psel    <= psel_n;
            ovf     <= ovf_n;
            cnt     <= cnt_n;
            reload  <= reload_n;
            irq_op  <= ovf_n && ie_n;
        end
    end

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: cycle table plus hand-written corner sequences.
module tb_bus_timer;

    logic       clk_ip = 1'b0;
    logic       reset;
    logic [7:0] bus_addr_ip, bus_wdata_ip;
    logic       bus_we_ip;
    logic [7:0] bus_rdata_op;
    logic       bus_sel_op, irq_op;

    bus_timer #(.BASE(8'hF0), .PRESC_W(7)) dut (
        .clk_ip       (clk_ip),
        .reset        (reset),
        .bus_addr_ip  (bus_addr_ip),
        .bus_wdata_ip (bus_wdata_ip),
        .bus_we_ip    (bus_we_ip),
        .bus_rdata_op (bus_rdata_op),
        .bus_sel_op   (bus_sel_op),
        .irq_op       (irq_op)
    );

    always #10 clk_ip = ~clk_ip;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       irq;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] rdata;
        logic       sel;
        logic       irq;
    } exp_t;

    vec_t vecs[19];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one bus cycle, queue the expectation, and score the combinational response.
    task automatic drive(input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] er, input logic ei, input string name);
        exp_t e;
        bus_we_ip    = w;
        bus_addr_ip  = a;
        bus_wdata_ip = d;
        e.name  = name;
        e.rdata = er;
        e.sel   = (a >= 8'hF0) && (a <= 8'hF3);
        e.irq   = ei;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        check8({e.name, ".rdata"}, bus_rdata_op, e.rdata);
        check8({e.name, ".sel"}, {7'd0, bus_sel_op}, {7'd0, e.sel});
        check8({e.name, ".irq"}, {7'd0, irq_op}, {7'd0, e.irq});
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] er, input logic ei, input string name);
        drive(1'b0, a, 8'h00, er, ei, name);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus_we_ip    = 1'b1;
        bus_addr_ip  = a;
        bus_wdata_ip = d;
        @(negedge clk_ip);
        bus_we_ip = 1'b0;
    endtask

    task automatic idle(input int n);
        bus_we_ip = 1'b0;
        repeat (n) @(negedge clk_ip);
    endtask

    initial begin
        // {we, addr, wdata, expected rdata, expected irq}, one record per cycle
        vecs[0]  = '{1'b0, 8'hF0, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 8'hF1, 8'h00, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 8'hF2, 8'h00, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 8'hF3, 8'h00, 8'hFF, 1'b0};
        vecs[4]  = '{1'b0, 8'h10, 8'h00, 8'h00, 1'b0};
        vecs[5]  = '{1'b1, 8'hF3, 8'h03, 8'hFF, 1'b0};
        vecs[6]  = '{1'b1, 8'hF0, 8'h05, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 8'hF2, 8'h00, 8'h00, 1'b0};
        vecs[8]  = '{1'b0, 8'hF2, 8'h00, 8'h01, 1'b0};
        vecs[9]  = '{1'b0, 8'hF2, 8'h00, 8'h02, 1'b0};
        vecs[10] = '{1'b0, 8'hF2, 8'h00, 8'h03, 1'b0};
        vecs[11] = '{1'b0, 8'hF1, 8'h00, 8'h03, 1'b1};
        vecs[12] = '{1'b1, 8'hF1, 8'h01, 8'h03, 1'b1};
        vecs[13] = '{1'b0, 8'hF1, 8'h00, 8'h02, 1'b0};
        vecs[14] = '{1'b0, 8'hF2, 8'h00, 8'h03, 1'b0};
        vecs[15] = '{1'b1, 8'hF0, 8'h00, 8'h05, 1'b1};
        vecs[16] = '{1'b0, 8'hF2, 8'h00, 8'h01, 1'b0};
        vecs[17] = '{1'b1, 8'hF1, 8'h01, 8'h01, 1'b0};
        vecs[18] = '{1'b0, 8'hF1, 8'h00, 8'h00, 1'b0};

        reset        = 1'b1;
        bus_we_ip    = 1'b0;
        bus_addr_ip  = 8'h00;
        bus_wdata_ip = 8'h00;
        repeat (2) @(negedge clk_ip);
        reset = 1'b0;

        // Reset state, free-running wrap with irq, w1c clear, stop.
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].irq,
                  $sformatf("vec%0d", i));
            @(negedge clk_ip);
        end

        // Oneshot with divide-by-8 prescaler.
        wr(8'hF2, 8'h00);
        wr(8'hF3, 8'h01);
        wr(8'hF0, 8'h1B);
        idle(7);
        rd(8'hF2, 8'h00, 1'b0, "os_cnt_before_tick");
        idle(1);
        rd(8'hF2, 8'h01, 1'b0, "os_cnt_first_tick");
        idle(7);
        rd(8'hF1, 8'h02, 1'b0, "os_stat_running");
        idle(1);
        rd(8'hF1, 8'h01, 1'b0, "os_stat_ovf");
        rd(8'hF0, 8'h1A, 1'b0, "os_ctrl_en_cleared");
        rd(8'hF2, 8'h00, 1'b0, "os_cnt_zero");
        idle(20);
        rd(8'hF2, 8'h00, 1'b0, "os_cnt_holds");

        // Clear on the overflow cycle loses; CNT write beats a tick.
        wr(8'hF1, 8'h01);
        wr(8'hF3, 8'h02);
        wr(8'hF2, 8'h00);
        wr(8'hF0, 8'h01);
        idle(2);
        wr(8'hF1, 8'h01);
        rd(8'hF1, 8'h03, 1'b0, "clr_vs_set");
        rd(8'hF2, 8'h00, 1'b0, "clr_vs_set_cnt");
        wr(8'hF2, 8'h40);
        rd(8'hF2, 8'h40, 1'b0, "cnt_write_wins");
        wr(8'hF0, 8'h00);
        rd(8'hF2, 8'h41, 1'b0, "cnt_after_stop");
        rd(8'hF1, 8'h01, 1'b0, "stat_after_stop");

        // RELOAD below CNT: silent pass through FF, one overflow at RELOAD.
        wr(8'hF1, 8'h01);
        wr(8'hF3, 8'h02);
        wr(8'hF2, 8'h05);
        wr(8'hF0, 8'h01);
        idle(250);
        rd(8'hF2, 8'hFF, 1'b0, "wrap_cnt_ff");
        rd(8'hF1, 8'h02, 1'b0, "wrap_no_ovf_ff");
        idle(1);
        rd(8'hF2, 8'h00, 1'b0, "wrap_cnt_00");
        rd(8'hF1, 8'h02, 1'b0, "wrap_silent");
        idle(2);
        rd(8'hF2, 8'h02, 1'b0, "wrap_cnt_02");
        rd(8'hF1, 8'h02, 1'b0, "wrap_no_ovf_02");
        idle(1);
        rd(8'hF2, 8'h00, 1'b0, "wrap_reload_cnt");
        rd(8'hF1, 8'h03, 1'b0, "wrap_reload_ovf");

        // Reset mid-count with irq asserted and a write in flight.
        wr(8'hF0, 8'h05);
        rd(8'hF1, 8'h03, 1'b1, "pre_reset_irq");
        reset        = 1'b1;
        bus_we_ip    = 1'b1;
        bus_addr_ip  = 8'hF2;
        bus_wdata_ip = 8'h77;
        @(negedge clk_ip);
        reset     = 1'b0;
        bus_we_ip = 1'b0;
        rd(8'hF0, 8'h00, 1'b0, "rst_ctrl");
        rd(8'hF1, 8'h00, 1'b0, "rst_stat");
        rd(8'hF2, 8'h00, 1'b0, "rst_cnt");
        rd(8'hF3, 8'hFF, 1'b0, "rst_reload");
        rd(8'h10, 8'h00, 1'b0, "rst_unmapped");

        // Unmapped and read-only writes are ignored.
        wr(8'hF4, 8'h07);
        rd(8'hF0, 8'h00, 1'b0, "unmapped_write");
        wr(8'hF1, 8'h02);
        rd(8'hF1, 8'h00, 1'b0, "ro_run_write");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
